iq_capture_buffer: RTL and testbench

//  Triggered snapshot buffer for the decimated baseband I/Q stream (downsampled_x/y + ce_out) from the

---
 rtl/iq_capture_buffer.sv | 188 ++++++++++++++++++
 tb/tb_iq_capture_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_capture_buffer.sv
// Triggered I/Q snapshot buffer: a circular RAM captures the decimated stream around a
// level-crossing or forced trigger, then the window is read back trigger-aligned.
module iq_capture_buffer #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 in_ce,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    input  logic                 arm,
    input  logic                 force_trig,
    input  logic                 trig_en,
    input  logic signed [DW-1:0] trig_level,
    input  logic [AW-1:0]        pre_len,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*DW-1:0]      rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        start_ptr
);

    localparam int DEPTH = 2**AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state, w_state;
    logic [AW-1:0]         r_wr_ptr, w_wr_ptr;
    logic [AW-1:0]         r_pre_cnt, w_pre_cnt;
    logic [AW-1:0]         r_pre_len, w_pre_len;
    logic [AW-1:0]         r_post_rem, w_post_rem;
    logic [AW-1:0]         r_start_ptr, w_start_ptr;
    logic signed [DW-1:0]  r_prev_x, w_prev_x;
    logic                  r_prev_valid, w_prev_valid;
    logic                  r_pend_force, w_pend_force;
    logic                  r_busy, r_done;
    logic                  w_we;
    logic                  w_cross, w_trig;
    logic [AW-1:0]         w_rd_ptr;
    logic [2*DW-1:0]       r_rd_data;
    logic [2*DW-1:0]       r_ram [DEPTH];

    assign w_cross = trig_en && r_prev_valid
                     && (r_prev_x < trig_level) && (in_x >= trig_level);
    assign w_trig  = r_pend_force || force_trig || w_cross;

    // Next-state, pointer and counter logic; arm overrides everything including a same-cycle sample
    always_comb begin
        w_state      = r_state;
        w_wr_ptr     = r_wr_ptr;
        w_pre_cnt    = r_pre_cnt;
        w_pre_len    = r_pre_len;
        w_post_rem   = r_post_rem;
        w_start_ptr  = r_start_ptr;
        w_prev_x     = r_prev_x;
        w_prev_valid = r_prev_valid;
        w_pend_force = r_pend_force;
        w_we         = 1'b0;
        if (arm) begin
            w_state      = (pre_len == {AW{1'b0}}) ? S_WAIT : S_PRE;
            w_wr_ptr     = {AW{1'b0}};
            w_pre_cnt    = {AW{1'b0}};
            w_prev_valid = 1'b0;
            w_pend_force = 1'b0;
            w_pre_len    = pre_len;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (force_trig) begin
                        w_pend_force = 1'b1;
                    end else begin
                        w_pend_force = r_pend_force;
                    end
                    if (in_ce) begin
                        w_we         = 1'b1;
                        w_wr_ptr     = r_wr_ptr + AW'(1);
                        w_pre_cnt    = r_pre_cnt + AW'(1);
                        w_prev_x     = in_x;
                        w_prev_valid = 1'b1;
                        if (w_pre_cnt == r_pre_len) begin
                            w_state = S_WAIT;
                        end else begin
                            w_state = S_PRE;
                        end
                    end else begin
                        w_state = S_PRE;
                    end
                end
                S_WAIT: begin
                    if (in_ce) begin
                        w_we         = 1'b1;
                        w_wr_ptr     = r_wr_ptr + AW'(1);
                        w_prev_x     = in_x;
                        w_prev_valid = 1'b1;
                        if (w_trig) begin
                            // DEPTH-1 is all ones in AW bits, so the subtraction never underflows
                            w_start_ptr  = r_wr_ptr - r_pre_len;
                            w_post_rem   = {AW{1'b1}} - r_pre_len;
                            w_pend_force = 1'b0;
                            w_state      = (w_post_rem == {AW{1'b0}}) ? S_DONE : S_POST;
                        end else begin
                            w_state = S_WAIT;
                        end
                    end else if (force_trig) begin
                        w_pend_force = 1'b1;
                    end else begin
                        w_pend_force = r_pend_force;
                    end
                end
                S_POST: begin
                    if (in_ce) begin
                        w_we         = 1'b1;
                        w_wr_ptr     = r_wr_ptr + AW'(1);
                        w_prev_x     = in_x;
                        w_prev_valid = 1'b1;
                        w_post_rem   = r_post_rem - AW'(1);
                        w_state      = (r_post_rem == AW'(1)) ? S_DONE : S_POST;
                    end else begin
                        w_state = S_POST;
                    end
                end
                default: begin
                    w_state = r_state;
                end
            endcase
        end
    end

    // Control state and status registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= {AW{1'b0}};
            r_pre_cnt    <= {AW{1'b0}};
            r_pre_len    <= {AW{1'b0}};
            r_post_rem   <= {AW{1'b0}};
            r_start_ptr  <= {AW{1'b0}};
            r_prev_x     <= {DW{1'b0}};
            r_prev_valid <= 1'b0;
            r_pend_force <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_wr_ptr     <= w_wr_ptr;
            r_pre_cnt    <= w_pre_cnt;
            r_pre_len    <= w_pre_len;
            r_post_rem   <= w_post_rem;
            r_start_ptr  <= w_start_ptr;
            r_prev_x     <= w_prev_x;
            r_prev_valid <= w_prev_valid;
            r_pend_force <= w_pend_force;
            r_busy       <= (w_state == S_PRE) || (w_state == S_WAIT) || (w_state == S_POST);
            r_done       <= (w_state == S_DONE);
        end
    end

    // Sample RAM write port; contents intentionally not reset
    always_ff @(posedge sys_clk) begin
        if (w_we && !rst) begin
            r_ram[r_wr_ptr] <= {in_x, in_y};
        end
    end

    assign w_rd_ptr = r_start_ptr + rd_addr;

    // Trigger-aligned registered read, read-first against a same-cycle write
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_rd_data <= {(2*DW){1'b0}};
        end else begin
            r_rd_data <= r_ram[w_rd_ptr];
        end
    end

    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign start_ptr = r_start_ptr;

endmodule

// File: tb/tb_iq_capture_buffer.sv
// Bench for iq_capture_buffer (AW=4): directed scenarios plus randomized captures checked
// against a sample-sequence model of where the trigger window falls.
module tb_iq_capture_buffer;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic                 sys_clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_ce = 1'b0;
    logic signed [DW-1:0] in_x = '0;
    logic signed [DW-1:0] in_y = '0;
    logic                 arm = 1'b0;
    logic                 force_trig = 1'b0;
    logic                 trig_en = 1'b0;
    logic signed [DW-1:0] trig_level = '0;
    logic [AW-1:0]        pre_len = '0;
    logic [AW-1:0]        rd_addr = '0;
    logic [2*DW-1:0]      rd_data;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        start_ptr;

    int total = 0;
    int bad   = 0;

    logic signed [DW-1:0] sx[$];
    logic signed [DW-1:0] sy[$];
    bit                   sf[$];

    iq_capture_buffer #(.DW(DW), .AW(AW)) dut (
        .sys_clk(sys_clk), .rst(rst), .in_ce(in_ce), .in_x(in_x), .in_y(in_y),
        .arm(arm), .force_trig(force_trig), .trig_en(trig_en), .trig_level(trig_level),
        .pre_len(pre_len), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .start_ptr(start_ptr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First sample index whose arrival triggers, from the rules on the sample sequence
    function automatic int find_trig(int pl, logic signed [DW-1:0] lvl, bit ten);
        bit forced = 1'b0;
        for (int k = 0; k < sx.size(); k++) begin
            if (sf[k]) forced = 1'b1;
            if (k >= pl) begin
                if (forced) return k;
                if (ten && k >= 1 && sx[k-1] < lvl && sx[k] >= lvl) return k;
            end
        end
        return -1;
    endfunction

    task automatic clear_q();
        sx.delete(); sy.delete(); sf.delete();
    endtask

    task automatic push(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y, input bit f);
        sx.push_back(x); sy.push_back(y); sf.push_back(f);
    endtask

    task automatic send(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y, input bit f);
        int gap;
        in_ce = 1'b1; in_x = x; in_y = y; force_trig = f;
        tick();
        in_ce = 1'b0; force_trig = 1'b0;
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic do_arm(input int pl, input bit with_ce);
        pre_len = AW'(pl);
        arm = 1'b1;
        in_ce = with_ce; in_x = 16'sd999; in_y = 16'sd999;
        tick();
        arm = 1'b0; in_ce = 1'b0;
        tick();
        check("busy_after_arm", {31'd0, busy}, 32'd1);
        check("done_after_arm", {31'd0, done}, 32'd0);
    endtask

    task automatic read_at(input int a, output logic [31:0] d);
        rd_addr = AW'(a);
        tick();
        d = rd_data;
    endtask

    // Arm, feed the queued samples through the expected end of window, then verify window
    task automatic run_capture(input int pl, input logic signed [DW-1:0] lvl, input bit ten,
                               input bit arm_ce, output int trig);
        int last;
        logic [31:0] d;
        trig_en = ten; trig_level = lvl;
        do_arm(pl, arm_ce);
        trig = find_trig(pl, lvl, ten);
        last = trig + DEPTH - pl - 1;
        if (trig < 0 || last >= sx.size()) begin
            bad++;
            $display("FAIL stimulus_len observed=%0d expected<%0d", last, sx.size());
            return;
        end
        for (int i = 0; i < last; i++) send(sx[i], sy[i], sf[i]);
        check("busy_before_last", {31'd0, busy}, 32'd1);
        check("done_before_last", {31'd0, done}, 32'd0);
        send(sx[last], sy[last], sf[last]);
        check("done_after_last", {31'd0, done}, 32'd1);
        check("busy_after_last", {31'd0, busy}, 32'd0);
        check("start_ptr", {28'd0, start_ptr}, 32'((trig - pl) % DEPTH));
        send(16'sh7777, 16'sh7777, 1'b0);
        send(16'sh7777, 16'sh7777, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            read_at(a, d);
            check($sformatf("window[%0d]", a), d, {sx[trig - pl + a], sy[trig - pl + a]});
        end
        check("done_stable", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int trig;
        int n;
        int pl;
        logic [31:0] d;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_start_ptr", {28'd0, start_ptr}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        tick();

        // Ramp with force at n=10, pre_len=4
        clear_q();
        for (int k = 0; k < 30; k++) push(DW'(k), DW'($urandom), k == 10);
        run_capture(4, 16'sd0, 1'b0, 1'b0, trig);
        read_at(4, d);  check("ramp_rd4_x", {16'd0, d[31:16]}, 32'd10);
        read_at(0, d);  check("ramp_rd0_x", {16'd0, d[31:16]}, 32'd6);
        read_at(15, d); check("ramp_rd15_x", {16'd0, d[31:16]}, 32'd21);

        // Rising crossing through 0, pre_len=2
        clear_q();
        push(-16'sd5, DW'($urandom), 1'b0);
        push(-16'sd3, DW'($urandom), 1'b0);
        push(-16'sd1, DW'($urandom), 1'b0);
        for (int k = 0; k < 25; k++) push(DW'(2 + 2 * k), DW'($urandom), 1'b0);
        run_capture(2, 16'sd0, 1'b1, 1'b0, trig);
        read_at(2, d); check("cross_rd2_x", {16'd0, d[31:16]}, 32'd2);
        read_at(1, d); check("cross_rd1_x", {16'd0, d[31:16]}, 32'h0000ffff);

        // pre_len=0, forced on the very first sample
        clear_q();
        for (int k = 0; k < 20; k++) push(DW'($urandom), DW'($urandom), k == 0);
        run_capture(0, 16'sd0, 1'b0, 1'b0, trig);
        read_at(0, d); check("pl0_rd0", d, {sx[0], sy[0]});

        // Crossing during PRE ignored; later crossing in WAIT triggers
        clear_q();
        for (int k = 0; k < 30; k++) begin
            if (k < 3)       push(-16'sd4, DW'($urandom), 1'b0);
            else if (k < 9)  push(16'sd3, DW'($urandom), 1'b0);
            else if (k < 11) push(-16'sd2, DW'($urandom), 1'b0);
            else             push(16'sd7, DW'($urandom), 1'b0);
        end
        run_capture(8, 16'sd0, 1'b1, 1'b0, trig);
        check("pre_cross_start", {28'd0, start_ptr}, 32'd3);

        // Re-arm mid-POST together with an in_ce (that sample is dropped)
        clear_q();
        for (int k = 0; k < 30; k++) push(DW'(100 + k), DW'($urandom), k == 6);
        trig_en = 1'b0;
        do_arm(3, 1'b0);
        for (int i = 0; i < 10; i++) send(sx[i], sy[i], sf[i]);
        check("midpost_busy", {31'd0, busy}, 32'd1);
        clear_q();
        for (int k = 0; k < 30; k++) push(DW'(200 + k), DW'($urandom), k == 5);
        run_capture(3, 16'sd0, 1'b0, 1'b1, trig);

        // Reset mid-POST with in_ce toggling
        clear_q();
        for (int k = 0; k < 30; k++) push(DW'(k), DW'($urandom), k == 2);
        do_arm(1, 1'b0);
        for (int i = 0; i < 6; i++) send(sx[i], sy[i], sf[i]);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_ce = i[0];
            tick();
        end
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_rd", rd_data, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_ce = ~i[0]; force_trig = ~i[0];
            tick();
        end
        in_ce = 1'b0; force_trig = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_start_ptr", {28'd0, start_ptr}, 32'd0);

        // Randomized captures
        for (int it = 0; it < 6; it++) begin
            int fi;
            bit ten;
            logic signed [DW-1:0] lvl;
            pl  = int'($urandom_range(0, DEPTH - 1));
            n   = pl + 60;
            fi  = int'($urandom_range(0, pl + 20));
            ten = 1'($urandom_range(0, 1));
            lvl = DW'(int'($urandom_range(0, 6)) - 3);
            clear_q();
            for (int k = 0; k < n; k++)
                push(DW'(int'($urandom_range(0, 16)) - 8), DW'($urandom), k == fi);
            run_capture(pl, lvl, ten, 1'($urandom_range(0, 1)), trig);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
